// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data memory.
package dmem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [31:0] DMEM_DEFAULT_BASE = 32'd1024;

  // Number of byte lanes in one memory word.
  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_addr_decode.sv
// Byte address to word index translation with range and alignment checking.
// Purely combinational.
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = DMEM_DEFAULT_BASE,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic [31:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             err
);

  localparam int unsigned BPW      = bytes_per_word(DATA_W);
  localparam logic [31:0] Bpw32    = 32'(BPW);
  // Window size kept one bit wider so a window filling the full 4 GiB still compares correctly.
  localparam logic [32:0] WinBytes = 33'(DEPTH * BPW);

  logic [31:0] off;

  // Offset from the window base; wraps for addresses below the base, caught by the first term.
  always_comb begin
    off = addr - BASE_ADDR;
    err = (addr < BASE_ADDR) | ({1'b0, off} >= WinBytes) | ((off % Bpw32) != 32'd0);
    idx = IDX_W'(off / Bpw32);
  end

endmodule

// File: rtl/dmem_banked_param.sv
// Parametrised word-addressed data memory with valid/ready request port,
// registered 1-cycle response, error checking and a clear sweep after reset.
// Optional macro DMEM_BYTE_WRITE_EN enables per-byte write masking via req_be.
module dmem_banked_param
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = DMEM_DEFAULT_BASE,
  localparam int unsigned IDX_W    = $clog2(DEPTH),
  localparam int unsigned BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [IDX_W-1:0]  dec_idx;
  logic              dec_err;
  logic              accept;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_mask;

`ifndef DMEM_BYTE_WRITE_EN
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  dmem_addr_decode #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr (req_addr),
    .idx  (dec_idx),
    .err  (dec_err)
  );

  // Ready and busy are pure decodes of the registered state.
  assign req_ready = (state_q == READY);
  assign init_busy = (state_q == CLEAR);
  assign accept    = req_valid && req_ready;

  // State and clear-pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep sequencing: one word per cycle, leave CLEAR after the last word.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: ;
    endcase
  end

  // Single write port shared by the clear sweep and accepted, error-free writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = dec_idx;
    wr_data = req_wdata;
    wr_mask = '1;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = ptr_q;
      wr_data = '0;
    end else if (accept && req_we && !dec_err) begin
      wr_en = 1'b1;
`ifdef DMEM_BYTE_WRITE_EN
      wr_mask = req_be;
`endif
    end
  end

  // Storage array; no reset, contents are initialised by the sweep.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wr_mask[k]) begin
          mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Response register: one strobe per accepted request, data only for good reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && dec_err;
      rsp_rdata_q <= (accept && !req_we && !dec_err) ? mem[dec_idx] : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_banked_param.sv
// Self-checking bench for dmem_banked_param: table-driven single requests
// plus hand-written sequences for sweep timing, reset and streaming.
module tb_dmem_banked_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef DMEM_BYTE_WRITE_EN
  localparam logic [31:0] ExpMerge = 32'h11BB33DD;
  localparam logic [31:0] ExpBe0   = 32'h0000_0000;
`else
  localparam logic [31:0] ExpMerge = 32'hAABBCCDD;
  localparam logic [31:0] ExpBe0   = 32'h0000_0099;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVec = 19;
  vec_t vecs [NVec];

  dmem_banked_param u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Count cycles with init_busy high starting at the current negedge; bounded.
  task automatic count_busy(input string name);
    int cnt = 0;
    while (init_busy === 1'b1 && cnt < 200) begin
      check({name, "_ready_low"}, 32'(req_ready), 32'd0);
      cnt++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(cnt), 32'd64);
    check({name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    check({name, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    @(negedge clk);
    req_valid = 1'b0;
    check({name, "_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_err"}, 32'(rsp_err), 32'(v.exp_err));
    check({name, "_rdata"}, rsp_rdata, v.exp_rdata);
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic exp_err,
                              input logic [31:0] exp_rdata);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  function automatic logic [31:0] sdata(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1'b0, 32'h400, 32'h0, 4'hF, 1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 32'h404, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 32'h404, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
    vecs[3]  = mk(1'b0, 32'h3FC, 32'h0, 4'hF, 1'b1, 32'h0);
    vecs[4]  = mk(1'b0, 32'h500, 32'h0, 4'hF, 1'b1, 32'h0);
    vecs[5]  = mk(1'b0, 32'h402, 32'h0, 4'hF, 1'b1, 32'h0);
    vecs[6]  = mk(1'b1, 32'h500, 32'h12345678, 4'hF, 1'b1, 32'h0);
    vecs[7]  = mk(1'b1, 32'h406, 32'h55555555, 4'hF, 1'b1, 32'h0);
    vecs[8]  = mk(1'b1, 32'h3FC, 32'h66666666, 4'hF, 1'b1, 32'h0);
    vecs[9]  = mk(1'b0, 32'h404, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
    vecs[10] = mk(1'b0, 32'h4FC, 32'h0, 4'hF, 1'b0, 32'h0);
    vecs[11] = mk(1'b1, 32'h4FC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    vecs[12] = mk(1'b0, 32'h4FC, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D);
    vecs[13] = mk(1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 1'b1, 32'h0);
    vecs[14] = mk(1'b1, 32'h408, 32'h11223344, 4'hF, 1'b0, 32'h0);
    vecs[15] = mk(1'b1, 32'h408, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0);
    vecs[16] = mk(1'b0, 32'h408, 32'h0, 4'hF, 1'b0, ExpMerge);
    vecs[17] = mk(1'b1, 32'h40C, 32'h00000099, 4'b0000, 1'b0, 32'h0);
    vecs[18] = mk(1'b0, 32'h40C, 32'h0, 4'hF, 1'b0, ExpBe0);

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(init_busy), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    count_busy("sweep1");

    // Table-driven single requests.
    for (int i = 0; i < NVec; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back write then read of the same word, with a single-cycle strobe check.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h410; req_wdata = 32'h0BADF00D; req_be = 4'hF;
    @(negedge clk);
    check("b2b_wr_valid", 32'(rsp_valid), 32'd1);
    check("b2b_wr_rdata", rsp_rdata, 32'd0);
    req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_rd_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rd_err", 32'(rsp_err), 32'd0);
    check("b2b_rd_rdata", rsp_rdata, 32'h0BADF00D);
    @(negedge clk);
    check("b2b_strobe_drop", 32'(rsp_valid), 32'd0);

    // Word 5 written, then reset coinciding with a request drops it.
    apply(mk(1'b1, 32'h414, 32'h5555AAAA, 4'hF, 1'b0, 32'h0), "w5_wr");
    apply(mk(1'b0, 32'h414, 32'h0, 4'hF, 1'b0, 32'h5555AAAA), "w5_rd");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h404; rst = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;
    check("rstreq_valid", 32'(rsp_valid), 32'd0);
    check("rstreq_rdata", rsp_rdata, 32'd0);
    check("rstreq_busy", 32'(init_busy), 32'd1);

    // Mid-sweep: a request is ignored, then reset at sweep cycle 30 restarts the sweep.
    for (int i = 0; i < 30; i++) begin
      if (i == 10) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h400; req_wdata = 32'hFFFFFFFF;
      end
      if (i == 12) begin
        check("clear_no_accept", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy("sweep2");
    apply(mk(1'b0, 32'h414, 32'h0, 4'hF, 1'b0, 32'h0), "w5_cleared");
    apply(mk(1'b0, 32'h400, 32'h0, 4'hF, 1'b0, 32'h0), "w0_cleared");

    // Streaming: 64 writes then 64 reads with req_valid held high.
    for (int s = 0; s <= 128; s++) begin
      @(negedge clk);
      if (s > 0) begin
        check($sformatf("stream%0d_valid", s - 1), 32'(rsp_valid), 32'd1);
        check($sformatf("stream%0d_rdata", s - 1), rsp_rdata,
              (s - 1 < 64) ? 32'd0 : sdata(s - 65));
      end
      if (s < 64) begin
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
        req_addr = 32'h400 + 32'(s) * 32'd4; req_wdata = sdata(s);
      end else if (s < 128) begin
        req_valid = 1'b1; req_we = 1'b0;
        req_addr = 32'h400 + 32'(s - 64) * 32'd4;
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("stream_end_valid", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_banked_param.md
Name: dmem_banked_param

Overview:
- Parametrised successor to the fixed 64-word data memory in the memory stage.
- Word-addressed SRAM model behind a valid/ready request port, with a registered 1-cycle response and a base-address window.
- Adds range and alignment checking with an error response, plus a hardware clear sweep after reset.
- Sits between the MEM stage / cache refill path and the backing store.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; must be a power of 2, at least 2.
- BASE_ADDR, 32'd1024, byte address of word 0.
- IDX_W, $clog2(DEPTH), localparam, word index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane write enables.
- rsp_valid  out  1  response strobe, one per accepted request.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  accepted request was out of range or misaligned.
- init_busy  out  1  clear sweep in progress.

Behaviour:
- Reset is synchronous and active-high. Clock is clk, reset is rst.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1. Clear pointer = 0. State = CLEAR.
- FSM states:
  - CLEAR: writes 0 to word[ptr] each cycle, then ptr++. After the cycle that writes ptr==DEPTH-1, goes to READY. Exactly DEPTH cycles.
  - READY: req_ready=1, init_busy=0.
- rst asserted in any state, including mid-sweep or mid-request, returns to CLEAR with ptr=0 and drops any pending response.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - At most one request per cycle; there is no response backpressure.
  - req_ready is a registered state decode only; it does not depend on req_valid.
- Address decode:
  - off = req_addr - BASE_ADDR, 32-bit unsigned.
  - err = (req_addr < BASE_ADDR) | (off >= DEPTH*DATA_W/8) | (off mod (DATA_W/8) != 0).
  - idx = off / (DATA_W/8), truncated to IDX_W.
- Latency: the response appears exactly 1 cycle after acceptance. rsp_valid is high for one cycle only.
  - Read: rsp_rdata = word[idx] as sampled at the accept edge.
  - Write: the memory is updated at the accept edge; rsp_rdata=0.
  - Error: no memory update; rsp_err=1; rsp_rdata=0.
- Cycles with no accepted request: rsp_valid=0, rsp_err=0, rsp_rdata=0.
- Back-to-back write then read of the same idx: the read returns the new data. Same-cycle conflicts cannot occur.
- idx=DEPTH-1 is valid. The first byte beyond the window gives err; no wrap-around.
- Requests during CLEAR are not accepted, and the memory contents are not observable.

Optional Feature:
- Macro: DMEM_BYTE_WRITE_EN.
- Defined: only byte lanes with req_be[k]=1 are written; the other lanes keep their old value.
- Defined: a write with req_be all-zero is a legal no-op and still responds with rsp_valid=1, rsp_err=0.
- Not defined: req_be is ignored and every write updates the full word.

Decomposition:
- Shared package dmem_pkg:
  - state enum {CLEAR, READY};
  - DMEM_DEFAULT_BASE = 32'd1024;
  - byte-lane count function bytes_per_word(DATA_W).
- One sub-module, dmem_addr_decode. It is purely combinational: req_addr in, idx and err out, parametrised by BASE_ADDR, DEPTH and DATA_W.

Test Plan:
- Reset, then idle: init_busy=1 and req_ready=0 for exactly 64 cycles; both flip at cycle 65. A read of 0x400 then returns 0.
- Write 0xDEADBEEF to 0x404; next cycle read 0x404: write rsp_valid 1 cycle after accept, read returns 0xDEADBEEF 1 cycle after its accept, rsp_err=0.
- Read 0x3FC, 0x500 and 0x402, one each: each gives rsp_valid=1, rsp_err=1, rsp_rdata=0, and memory is unchanged. Read 0x4FC is legal.
- Assert rst for 1 cycle at sweep cycle 30 after word 5 was written: the sweep restarts and takes a full 64 cycles, and word 5 reads back 0.
- With DMEM_BYTE_WRITE_EN: write 0x11223344 to 0x408, then write 0xAABBCCDD with be=4'b0101: a read of 0x408 returns 0x11BB33DD. Without the macro it returns 0xAABBCCDD.
- Streaming: 64 consecutive writes then 64 reads with req_valid held high: one response every cycle and all data matches.
